// File: rtl/sprite_disp_pkg.sv
// Shared types, command encodings and default tables for the sprite layer.
// Horizontal flip support is selected with the SPRITE_HFLIP_EN macro.
package sprite_disp_pkg;

    localparam logic [3:0] ACT_SWAP   = 4'hF;
    localparam logic [3:0] ACT_UPDATE = 4'h1;

    localparam logic [2:0] TYP_ATTR  = 3'b001;
    localparam logic [2:0] TYP_X     = 3'b010;
    localparam logic [2:0] TYP_Y     = 3'b011;
    localparam logic [2:0] TYP_FRAME = 3'b100;

    typedef struct packed {
        logic [5:0]  comp;
        logic [4:0]  child;
        logic [3:0]  action;
        logic [2:0]  typ;
        logic        bsel;
        logic [12:0] data;
    } cmd_t;

    typedef struct packed {
        logic [15:0] base;
        logic [7:0]  w;
        logic [7:0]  h;
    } pattern_t;

    typedef struct packed {
        logic       visible;
        logic       flip;
        logic [4:0] pattern;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] frame;
    } sprite_state_t;

    function automatic pattern_t pattern_entry(input logic [4:0] idx);
        pattern_t p;
        case (idx)
            5'd1:    p = '{base: 16'd258,  w: 8'd16, h: 8'd16};
            5'd2:    p = '{base: 16'd512,  w: 8'd8,  h: 8'd8};
            5'd3:    p = '{base: 16'd1016, w: 8'd16, h: 8'd16};
            default: p = '{base: 16'd0,    w: 8'd16, h: 8'd16};
        endcase
        return p;
    endfunction

    function automatic logic [23:0] palette_color(input logic [7:0] idx);
        logic [23:0] c;
        case (idx)
            8'd1:    c = 24'hFF0000;
            8'd2:    c = 24'h00FF00;
            8'd3:    c = 24'h0000FF;
            default: c = {idx, idx, idx};
        endcase
        return c;
    endfunction

    // Built-in pixel image: each pixel index is its address plus one.
    function automatic logic [7:0] rom_pixel(input logic [15:0] addr);
        return addr[7:0] + 8'd1;
    endfunction

endpackage

// File: rtl/sprite_addr_calc.sv
// Stage-1 hit test and pixel address for one sprite instance.
// Mirrors the column when SPRITE_HFLIP_EN is defined.
module sprite_addr_calc
    import sprite_disp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic        visible_i,
`ifdef SPRITE_HFLIP_EN
    input  logic        flip_i,
`endif
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic [9:0]  frame_i,
    input  logic [31:0] pat_i,
    output logic        hit_o,
    output logic [15:0] addr_o
);

    pattern_t    pat;
    logic [10:0] rel_x;
    logic [10:0] rel_y;
    logic [10:0] col;
    logic        hit_d;
    logic        hit_q;
    logic [15:0] addr_d;
    logic [15:0] addr_q;

    assign pat = pattern_t'(pat_i);

    always_comb begin
        rel_x = {1'b0, hcount_i} - {1'b0, x_i};
        rel_y = {1'b0, vcount_i} - {1'b0, y_i};
        hit_d = visible_i
             && (rel_x < {3'b0, pat.w})
             && (rel_y < {3'b0, pat.h});
`ifdef SPRITE_HFLIP_EN
        col = flip_i ? ({3'b0, pat.w} - 11'd1 - rel_x) : rel_x;
`else
        col = rel_x;
`endif
        addr_d = pat.base
               + 16'(frame_i) * 16'(pat.w) * 16'(pat.h)
               + 16'(rel_y) * 16'(pat.w)
               + 16'(col);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            hit_q  <= hit_d;
            addr_q <= addr_d;
        end
    end

    assign hit_o  = hit_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/sprite_layer_display.sv
// Double-buffered multi-instance sprite layer with a 3-stage pixel pipeline.
// Optional horizontal flip is enabled by defining SPRITE_HFLIP_EN.
module sprite_layer_display
    import sprite_disp_pkg::*;
#(
    parameter logic [5:0]  COMPONENT_ID = 6'd5,
    parameter int          NUM_CHILDREN = 8,
    parameter int          NUM_PATTERNS = 4,
    parameter int          PIX_BITS     = 2,
    parameter int          MEM_DEPTH    = 1024,
    parameter string       MEM_FILE     = "",
    parameter logic [23:0] BG_COLOR     = 24'h202020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [23:0] RGB_output
);

    localparam bit unused_mem_file = (MEM_FILE != "");

    cmd_t          cmd;
    sprite_state_t st_q [2][NUM_CHILDREN];
    sprite_state_t st_d [2][NUM_CHILDREN];
    logic          front_sel_q;
    logic          front_sel_d;
    logic          swap_pending_q;
    logic          swap_pending_d;
    logic          swap_target_q;
    logic          swap_target_d;
    logic          commit;
    logic          upd;
    logic          unused_cmd;

    assign cmd        = cmd_t'(writedata);
    assign unused_cmd = cmd.data[10];
    assign commit     = swap_pending_q && (hcount == 10'd0) && (vcount == 10'd0);
    assign upd        = write && (cmd.action == ACT_UPDATE)
                     && (cmd.comp == COMPONENT_ID);

    // Commit clears the new back buffer first so a same-cycle write survives.
    always_comb begin
        st_d           = st_q;
        front_sel_d    = front_sel_q;
        swap_pending_d = swap_pending_q;
        swap_target_d  = swap_target_q;
        if (commit) begin
            front_sel_d    = swap_target_q;
            swap_pending_d = 1'b0;
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                st_d[~swap_target_q][i].visible = 1'b0;
            end
        end
        if (write && (cmd.action == ACT_SWAP)) begin
            swap_pending_d = 1'b1;
            swap_target_d  = cmd.bsel;
        end
        if (upd) begin
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                if (cmd.child == 5'(i)) begin
                    case (cmd.typ)
                        TYP_ATTR: begin
                            st_d[cmd.bsel][i].visible = cmd.data[12];
                            st_d[cmd.bsel][i].flip    = cmd.data[11];
                            if (32'(cmd.data[4:0]) < NUM_PATTERNS) begin
                                st_d[cmd.bsel][i].pattern = cmd.data[4:0];
                            end
                        end
                        TYP_X:     st_d[cmd.bsel][i].x     = cmd.data[9:0];
                        TYP_Y:     st_d[cmd.bsel][i].y     = cmd.data[9:0];
                        TYP_FRAME: st_d[cmd.bsel][i].frame = cmd.data[9:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_target_q  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_CHILDREN; i++) begin
                    st_q[b][i] <= '0;
                end
            end
        end else begin
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            swap_target_q  <= swap_target_d;
            st_q           <= st_d;
        end
    end

    logic                hit_s1  [NUM_CHILDREN];
    logic [15:0]         addr_s1 [NUM_CHILDREN];
    logic [PIX_BITS-1:0] idx_q   [NUM_CHILDREN];

    for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_child
        sprite_addr_calc u_calc (
            .clk       (clk),
            .reset     (reset),
            .hcount_i  (hcount),
            .vcount_i  (vcount),
            .visible_i (st_q[front_sel_q][i].visible),
`ifdef SPRITE_HFLIP_EN
            .flip_i    (st_q[front_sel_q][i].flip),
`endif
            .x_i       (st_q[front_sel_q][i].x),
            .y_i       (st_q[front_sel_q][i].y),
            .frame_i   (st_q[front_sel_q][i].frame),
            .pat_i     (pattern_entry(st_q[front_sel_q][i].pattern)),
            .hit_o     (hit_s1[i]),
            .addr_o    (addr_s1[i])
        );
`ifndef SPRITE_HFLIP_EN
        logic unused_flip;
        assign unused_flip = st_q[front_sel_q][i].flip;
`endif
    end

    // Misses and out-of-image addresses read as transparent, never as colour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                if (hit_s1[i] && (32'(addr_s1[i]) < MEM_DEPTH)) begin
                    idx_q[i] <= PIX_BITS'(rom_pixel(addr_s1[i]));
                end else begin
                    idx_q[i] <= '0;
                end
            end
        end
    end

    logic [PIX_BITS-1:0] win;
    logic [23:0]         rgb_d;
    logic [23:0]         rgb_q;

    always_comb begin
        win = '0;
        for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
            if (idx_q[i] != '0) begin
                win = idx_q[i];
            end
        end
        rgb_d = (win != '0) ? palette_color(8'(win)) : BG_COLOR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q <= BG_COLOR;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign RGB_output = rgb_q;

endmodule

// File: tb/tb_sprite_layer_display.sv
// Directed bench for sprite_layer_display with a 3-deep expectation queue.
// Flip expectations follow SPRITE_HFLIP_EN.
module tb_sprite_layer_display;

    localparam logic [23:0] BG = 24'h202020;
    localparam logic [23:0] P1 = 24'hFF0000;
    localparam logic [23:0] P2 = 24'h00FF00;
    localparam logic [23:0] P3 = 24'h0000FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [31:0] writedata;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [23:0] RGB_output;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          chk;
        logic [23:0] rgb;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    sprite_layer_display dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .writedata  (writedata),
        .hcount     (hcount),
        .vcount     (vcount),
        .RGB_output (RGB_output)
    );

    function automatic logic [31:0] mk(input int comp, input int child,
                                       input int act, input int typ,
                                       input int b, input int data);
        return {6'(comp), 5'(child), 4'(act), 3'(typ), 1'(b), 13'(data)};
    endfunction

    function automatic logic [31:0] attr(input int child, input int b,
                                         input int vis, input int flip,
                                         input int pat);
        return mk(5, child, 1, 1, b, (vis << 12) | (flip << 11) | pat);
    endfunction

    function automatic logic [31:0] setx(input int child, input int b, input int v);
        return mk(5, child, 1, 2, b, v);
    endfunction

    function automatic logic [31:0] sety(input int child, input int b, input int v);
        return mk(5, child, 1, 3, b, v);
    endfunction

    function automatic logic [31:0] swap(input int b);
        return mk(0, 0, 15, 0, b, 0);
    endfunction

    task automatic step(input int h, input int v, input bit we,
                        input logic [31:0] wd, input bit chk,
                        input logic [23:0] rgb, input string tag);
        @(negedge clk);
        hcount    = 10'(h);
        vcount    = 10'(v);
        write     = we;
        writedata = wd;
        sb.push_back('{chk, rgb, tag});
    endtask

    task automatic cmd(input logic [31:0] wd);
        step(700, 500, 1'b1, wd, 1'b0, BG, "cmd");
    endtask

    task automatic look(input int h, input int v, input logic [23:0] rgb,
                        input string tag);
        step(h, v, 1'b0, 32'd0, 1'b1, rgb, tag);
    endtask

    task automatic idle3();
        repeat (3) step(700, 500, 1'b0, 32'd0, 1'b0, BG, "idle");
    endtask

    task automatic check_now(input logic [23:0] exp, input string tag);
        checks++;
        assert (RGB_output === exp)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, RGB_output, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() == 3) begin
            mon_e = sb.pop_front();
            if (mon_e.chk) begin
                checks++;
                assert (RGB_output === mon_e.rgb)
                else begin
                    failures++;
                    $error("FAIL %s got=%h exp=%h", mon_e.tag, RGB_output, mon_e.rgb);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        write     = 1'b0;
        writedata = 32'd0;
        hcount    = 10'd700;
        vcount    = 10'd500;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_now(BG, "reset_rgb");
        @(negedge clk);
        reset = 1'b1;

        look(100, 50, BG, "empty_bg");

        // single sprite in buffer 0
        cmd(attr(0, 0, 1, 0, 0));
        cmd(setx(0, 0, 100));
        cmd(sety(0, 0, 50));
        cmd(swap(0));
        step(0, 0, 1'b0, 32'd0, 1'b0, BG, "commit0");
        look(100, 50, P1, "t2_origin");
        look(99, 50, BG, "t2_left");
        look(102, 50, P3, "t2_px2");
        look(103, 50, BG, "t2_transp");
        look(100, 65, P1, "t2_lastrow");
        look(100, 66, BG, "t2_below");
        look(116, 50, BG, "t2_right");
        look(100, 49, BG, "t2_above");

        // overlap priority
        cmd(attr(1, 0, 1, 0, 1));
        cmd(setx(1, 0, 200));
        cmd(sety(1, 0, 80));
        cmd(setx(0, 0, 200));
        cmd(sety(0, 0, 80));
        look(200, 80, P1, "t3_c0wins");
        look(202, 80, P3, "t3_c0wins2");
        look(203, 80, P2, "t3_c1shows");

        // double buffering
        cmd(attr(0, 1, 1, 0, 0));
        cmd(setx(0, 1, 300));
        cmd(sety(0, 1, 80));
        step(10, 120, 1'b1, swap(0), 1'b0, BG, "swap_a");
        step(10, 120, 1'b1, swap(1), 1'b0, BG, "swap_b");
        look(200, 80, P1, "t4_before");
        look(300, 80, BG, "t4_notyet");
        step(0, 0, 1'b0, 32'd0, 1'b0, BG, "commit1");
        look(300, 80, P1, "t4_after");
        look(200, 80, BG, "t4_oldgone");
        cmd(swap(0));
        step(0, 0, 1'b1, attr(0, 1, 1, 0, 0), 1'b0, BG, "commit0w");
        look(200, 80, BG, "t4_buf0_cleared");
        look(300, 80, BG, "t4_back_hidden");
        cmd(swap(1));
        step(0, 0, 1'b0, 32'd0, 1'b0, BG, "commit1b");
        look(300, 80, P1, "t4_write_wins");

        // ROM bound and ignored commands
        cmd(attr(0, 1, 1, 0, 3));
        look(300, 80, P1, "t5_in_rom");
        look(308, 80, BG, "t5_past_rom");
        look(315, 95, BG, "t5_far");
        cmd(mk(5, 8, 1, 2, 1, 0));
        cmd(mk(6, 0, 1, 2, 1, 0));
        cmd(mk(5, 0, 2, 2, 1, 0));
        cmd(mk(5, 0, 1, 5, 1, 0));
        cmd(attr(0, 1, 1, 0, 5));
        look(300, 80, P1, "t5_no_change");
        look(308, 80, BG, "t5_still_oob");

        // flip
        cmd(attr(2, 1, 1, 1, 1));
        cmd(setx(2, 1, 400));
        cmd(sety(2, 1, 80));
`ifdef SPRITE_HFLIP_EN
        look(400, 80, P2, "t6_flip_left");
        look(415, 80, P3, "t6_flip_right");
`else
        look(400, 80, P3, "t6_noflip_left");
        look(415, 80, P2, "t6_noflip_right");
`endif

        // reset mid-frame
        look(300, 80, P1, "t1_pre");
        idle3();
        #2 reset = 1'b0;
        sb.delete();
        #1 check_now(BG, "t1_async");
        step(300, 80, 1'b0, 32'd0, 1'b0, BG, "rst");
        @(posedge clk);
        #1 check_now(BG, "t1_hold");
        step(300, 80, 1'b0, 32'd0, 1'b0, BG, "rst");
        reset = 1'b1;
        look(300, 80, BG, "t1_lost_a");
        look(300, 80, BG, "t1_lost_b");
        look(400, 80, BG, "t1_lost_c");
        cmd(attr(0, 0, 1, 0, 0));
        cmd(setx(0, 0, 300));
        cmd(sety(0, 0, 80));
        look(300, 80, P1, "t1_reprog");

        idle3();
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
